// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - gray/binary pointer conversion shared by the dual-clock FIFO
package async_fifo_pkg;

  // Pointers of any width up to PTR_MAX_W are zero-extended into this word.
  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    ptr_word_t gray;
    gray[PTR_MAX_W-1] = bin[PTR_MAX_W-1];
    for (int i = 0; i < PTR_MAX_W - 1; i++) begin
      gray[i] = bin[i] ^ bin[i+1];
    end
    return gray;
  endfunction

  // Zero-extended upper bits leave the low-order result unchanged.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop gray pointer synchroniser with binary output
module gray_sync
  import async_fifo_pkg::*;
#(
  parameter int W      = 9,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= gray;
      for (int i = 1; i < N; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bin = W'(gray2bin(PTR_MAX_W'(stage_q[N-1])));

endmodule

// File: rtl/async_fifo_prog.sv
// rtl/async_fifo_prog.sv - dual-clock FIFO with programmable thresholds, levels and sticky error flags
module async_fifo_prog
  import async_fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              winc,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W:0]   wafull_th,
  output logic              wfull,
  output logic              wafull,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf,
  input  logic              rinc,
  input  logic [ADDR_W:0]   raempty_th,
  output logic [DATA_W-1:0] rdata,
  output logic              rempty,
  output logic              raempty,
  output logic [ADDR_W:0]   rlevel,
  output logic              rudf
);

  localparam int              PW         = ADDR_W + 1;
  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = PW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wbin, wgray, wrbin, wbin_next;
  logic [ADDR_W:0] rbin, rgray, rwbin, rbin_next;
  logic [ADDR_W:0] mem_level;
  logic            wen;
  logic            mem_rd;

  // Write domain
  assign wen       = winc & ~wfull;
  assign wbin_next = wbin + PW'(1);

  always_ff @(posedge wclk) begin
    if (wen) begin
      mem[wbin[ADDR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wgray <= '0;
      wovf  <= 1'b0;
    end else begin
      if (wen) begin
        wbin  <= wbin_next;
        wgray <= PW'(bin2gray(PTR_MAX_W'(wbin_next)));
      end
      if (winc && wfull) begin
        wovf <= 1'b1;
      end
    end
  end

  gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .gray  (rgray),
    .bin   (wrbin)
  );

  assign wlevel = wbin - wrbin;
  assign wfull  = (wlevel == FULL_LEVEL);
  assign wafull = (wlevel >= wafull_th);

  // Read domain: rbin counts words taken out of the memory array.
  assign rbin_next = rbin + PW'(1);
  assign mem_level = rwbin - rbin;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin  <= '0;
      rgray <= '0;
      rdata <= '0;
      rudf  <= 1'b0;
    end else begin
      if (mem_rd) begin
        rbin  <= rbin_next;
        rgray <= PW'(bin2gray(PTR_MAX_W'(rbin_next)));
        rdata <= mem[rbin[ADDR_W-1:0]];
      end
      if (rinc && rempty) begin
        rudf <= 1'b1;
      end
    end
  end

  gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_w2r (
    .clk   (rclk),
    .rst_n (rrst_n),
    .gray  (wgray),
    .bin   (rwbin)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // rdata is a prefetch register; a pop refills it in the same cycle.
      logic valid;

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          valid <= 1'b0;
        end else if (mem_rd) begin
          valid <= 1'b1;
        end else if (rinc) begin
          valid <= 1'b0;
        end
      end

      assign mem_rd = (mem_level != '0) && (!valid || rinc);
      assign rempty = ~valid;
      assign rlevel = mem_level + PW'(valid);
    end else begin : g_reg
      assign mem_rd = rinc && (mem_level != '0);
      assign rempty = (mem_level == '0);
      assign rlevel = mem_level;
    end
  endgenerate

  assign raempty = (rlevel <= raempty_th);

endmodule
